// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential shift-add multiplier for WIDTH-bit operands, unsigned or
//   two's-complement. Magnitudes are multiplied with one conditional add per
//   cycle and the sign is applied once at the end. start is taken only when
//   idle; done pulses for one cycle when product/iter_count update.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous active-high reset, aborts any operation
//   start        operation request, sampled only in IDLE
//   signed_mode  0 = unsigned, 1 = two's-complement (sampled with start)
//   multiplicand operand A (sampled with start)
//   multiplier   operand B (sampled with start)
//   busy         high while in CALC or FIX
//   done         one-cycle pulse, product valid from this cycle on
//   product      2*WIDTH-bit result, held until the next done
//   iter_count   CALC iterations used by the last completed operation
module shift_add_multiplier #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [$clog2(WIDTH):0] iter_count
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               last_iter;

  // Magnitude of an operand. In signed mode the most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic            is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  // Final sign application on the 2*WIDTH-bit magnitude product.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic               make_neg);
    return make_neg ? -mag : mag;
  endfunction

  // The iteration being executed now is the last one when it is the WIDTH-th,
  // or (early exit) when no set bits remain above the bit consumed this cycle.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) ||
                     (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == CALC) || (state == FIX);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      product    <= '0;
      iter_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude(multiplicand, signed_mode)};
            mplier <= magnitude(multiplier, signed_mode);
            neg    <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          product    <= apply_sign(acc, neg);
          iter_count <= cnt;
        end
        default: ;
      endcase
    end
  end

endmodule
